// File: rtl/ex_mem_wb_pkg.sv
// Shared types for the EX/MEM/WB back end: memory-access FSM states and the EX/MEM payload.
package ex_mem_wb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_WAIT
  } mem_state_e;

  // The payload is sized by the package defaults; the top-level widths must match them.
  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] alu_result;
    logic [DATA_W_DEF-1:0] store_data;
  } ex_mem_t;

  function automatic logic is_mem_op(input ex_mem_t s);
    return s.valid & (s.mem_read | s.mem_write);
  endfunction

endpackage

// File: rtl/ex_mem_wb_pipeline_mem_access_fsm.sv
// Data-memory access sequencer: tracks IDLE/ACCESS/WAIT and generates the upstream stall.
// With MEM_TIMEOUT_EN defined, a WAIT lasting TIMEOUT_CYCLES abandons the access and sets mem_error.
module mem_access_fsm
  import ex_mem_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic next_mem_op,
  input  logic dmem_ready,
  output logic stall_out,
  output logic abort,
  output logic mem_error
);

  mem_state_e state_q, state_d;
  logic       timeout;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_error_q, mem_error_d;

  assign timeout   = (state_q == ST_WAIT) && (wait_cnt_q >= CNT_W'(TIMEOUT_CYCLES)) && !dmem_ready;
  assign mem_error = mem_error_q;
`else
  assign timeout   = 1'b0;
  assign mem_error = 1'b0;
`endif

  // A non-IDLE state means EX/MEM holds a memory op, so a ready memory never stalls.
  assign stall_out = (state_q != ST_IDLE) & ~dmem_ready & ~timeout;
  assign abort     = timeout;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = ST_IDLE;
    if (stall_out) begin
      state_d = ST_WAIT;
    end else if (next_mem_op) begin
      state_d = ST_ACCESS;
    end
`ifdef MEM_TIMEOUT_EN
    wait_cnt_d = '0;
    if (stall_out && (state_q == ST_WAIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
    mem_error_d = mem_error_q | timeout;
`endif
  end

  // NOTE: non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
`endif
    end
  end

endmodule

// File: rtl/ex_mem_wb_pipeline.sv
// EX/MEM and MEM/WB pipeline registers, data-memory handshake and forwarding sources.
// Optional memory timeout enabled by defining MEM_TIMEOUT_EN.
module ex_mem_wb_pipeline
  import ex_mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [ADDR_W-1:0] ex_write_reg_addr,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              flush,
  output logic              dmem_re,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready,
  output logic              stall_out,
  output logic              ex_mem_reg_write,
  output logic [ADDR_W-1:0] ex_mem_write_reg_addr,
  output logic [DATA_W-1:0] ex_mem_alu_result,
  output logic              ex_mem_mem_read,
  output logic              mem_wb_reg_write,
  output logic [ADDR_W-1:0] mem_wb_write_reg_addr,
  output logic [DATA_W-1:0] mem_wb_write_data,
  output logic              mem_error
);

  ex_mem_t           ex_mem_q, ex_mem_d;
  logic              mem_wb_reg_write_q, mem_wb_reg_write_d;
  logic [ADDR_W-1:0] mem_wb_addr_q, mem_wb_addr_d;
  logic [DATA_W-1:0] mem_wb_data_q, mem_wb_data_d;
  logic              cap_valid;
  logic              abort;

  assign cap_valid = ex_valid & ~flush;

  // While stalled the EX instruction is held upstream, so a flush then is ignored.
  always_comb begin
    ex_mem_d = ex_mem_q;
    if (!stall_out) begin
      ex_mem_d.valid      = cap_valid;
      ex_mem_d.reg_write  = cap_valid & ex_reg_write & ~ex_mem_write;
      ex_mem_d.mem_read   = cap_valid & ex_mem_read;
      ex_mem_d.mem_write  = cap_valid & ex_mem_write;
      ex_mem_d.addr       = ex_write_reg_addr;
      ex_mem_d.alu_result = ex_alu_result;
      ex_mem_d.store_data = ex_store_data;
    end
  end

  always_comb begin
    mem_wb_reg_write_d = ex_mem_q.valid & ex_mem_q.reg_write & ~stall_out & ~abort;
    mem_wb_addr_d      = ex_mem_q.addr;
    mem_wb_data_d      = ex_mem_q.mem_read ? dmem_rdata : ex_mem_q.alu_result;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_mem_q           <= '0;
      mem_wb_reg_write_q <= 1'b0;
      mem_wb_addr_q      <= '0;
      mem_wb_data_q      <= '0;
    end else begin
      ex_mem_q           <= ex_mem_d;
      mem_wb_reg_write_q <= mem_wb_reg_write_d;
      mem_wb_addr_q      <= mem_wb_addr_d;
      mem_wb_data_q      <= mem_wb_data_d;
    end
  end

  mem_access_fsm #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_mem_access_fsm (
    .clk        (clk),
    .reset      (reset),
    .next_mem_op(is_mem_op(ex_mem_d)),
    .dmem_ready (dmem_ready),
    .stall_out  (stall_out),
    .abort      (abort),
    .mem_error  (mem_error)
  );

  assign dmem_re    = ex_mem_q.valid & ex_mem_q.mem_read & ~abort;
  assign dmem_we    = ex_mem_q.valid & ex_mem_q.mem_write & ~abort;
  assign dmem_addr  = ex_mem_q.alu_result;
  assign dmem_wdata = ex_mem_q.store_data;

  assign ex_mem_reg_write      = ex_mem_q.valid & ex_mem_q.reg_write;
  assign ex_mem_write_reg_addr = ex_mem_q.addr;
  assign ex_mem_alu_result     = ex_mem_q.alu_result;
  assign ex_mem_mem_read       = ex_mem_q.valid & ex_mem_q.mem_read;

  assign mem_wb_reg_write      = mem_wb_reg_write_q;
  assign mem_wb_write_reg_addr = mem_wb_addr_q;
  assign mem_wb_write_data     = mem_wb_data_q;

endmodule

// File: doc/ex_mem_wb_pipeline.md
Name: ex_mem_wb_pipeline

Overview:
- Producer side of the EX-stage forwarding interface.
- Holds the EX/MEM and MEM/WB pipeline registers and drives the data-memory handshake.
- Publishes the write-back destination, write-enable and data that the forwarding unit and register file consume.
- Stalls upstream stages while a data-memory access is outstanding.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register-address width.
- TIMEOUT_CYCLES, 16, maximum memory wait cycles. Used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- ex_valid  in  1  EX stage holds a real instruction.
- ex_reg_write  in  1  instruction writes the register file.
- ex_mem_read  in  1  load.
- ex_mem_write  in  1  store.
- ex_write_reg_addr  in  ADDR_W  destination register.
- ex_alu_result  in  DATA_W  ALU result, or memory address for loads/stores.
- ex_store_data  in  DATA_W  store data.
- flush  in  1  squash the instruction currently in EX.
- dmem_re  out  1  memory read request.
- dmem_we  out  1  memory write request.
- dmem_addr  out  DATA_W  equals ex_mem_alu_result.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  load data, valid when dmem_ready is high.
- dmem_ready  in  1  access completes this cycle.
- stall_out  out  1  freeze PC, IF/ID and ID/EX.
- ex_mem_reg_write  out  1  forwarding source, qualified by valid.
- ex_mem_write_reg_addr  out  ADDR_W  forwarding source.
- ex_mem_alu_result  out  DATA_W  forwarding data.
- ex_mem_mem_read  out  1  load in MEM, for load-use detection.
- mem_wb_reg_write  out  1  register-file write enable and forwarding source.
- mem_wb_write_reg_addr  out  ADDR_W  write-back register.
- mem_wb_write_data  out  DATA_W  load data or ALU result.
- mem_error  out  1  sticky timeout flag. Tied 0 without the optional feature.

Behaviour:
- Reset:
  - All outputs and registers clear to 0; FSM returns to IDLE.
  - Reset in the middle of a WAIT abandons the access; nothing is written back.
- EX/MEM valid:
  - Internal ex_mem_valid <= ex_valid & ~flush.
  - All ex_mem_* controls are ANDed with valid, so a bubble never asserts reg_write or a memory request.
- Capture:
  - EX/MEM loads every cycle unless stall_out is high; then it holds.
  - flush while stall_out is high is ignored, because the EX instruction is also held upstream.
- Memory requests:
  - dmem_re/dmem_we are combinational from the EX/MEM contents (valid & mem_read / mem_write).
  - They stay asserted until dmem_ready.
- FSM states:
  - IDLE: no memory op in EX/MEM.
  - ACCESS: memory op present, first cycle.
  - WAIT: dmem_ready still low.
- FSM transitions:
  - IDLE -> ACCESS when a memory op is captured.
  - ACCESS -> IDLE if dmem_ready; the next op may be captured the same edge, giving ACCESS again.
  - ACCESS -> WAIT if not ready.
  - WAIT -> IDLE/ACCESS on dmem_ready, as above.
- stall_out = memory op in EX/MEM & ~dmem_ready. It is combinational, so a zero-wait memory never stalls.
- MEM/WB update:
  - While stall_out is high, MEM/WB receives a bubble (reg_write = 0).
  - Otherwise MEM/WB captures EX/MEM. mem_wb_write_data = dmem_rdata for loads, else ex_mem_alu_result.
- Latency: an ALU op is visible on ex_mem_* 1 cycle after EX and on mem_wb_* after 2 cycles; loads add the extra memory wait cycles.
- Register 0: writes to address 0 still propagate reg_write. Consumers ignore address 0; this block does not mask it.
- Back-to-back loads: the second load is captured the cycle the first completes, so there is no gap cycle with a ready memory.
- Store: mem_wb_reg_write is 0 regardless of ex_reg_write.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A wait counter increments every cycle in WAIT.
  - When the counter reaches TIMEOUT_CYCLES: abandon the access, set mem_error sticky until reset, return to IDLE, drop stall_out, and write back a bubble.
- Undefined: no counter, mem_error tied 0, wait is unbounded.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, ACCESS, WAIT).
  - DATA_W/ADDR_W defaults.
  - A struct for the EX/MEM payload (valid, reg_write, mem_read, mem_write, addr, alu_result, store_data).
- Sub-module: mem_access_fsm, containing the FSM, stall generation and the timeout counter. The pipeline registers stay in the top level.

Test Plan:
- Reset then ALU op (ex_valid = 1, reg_write = 1, addr = 5, result = 0x1234) -> ex_mem_write_reg_addr = 5 at cycle 1; mem_wb_write_data = 0x1234 with mem_wb_reg_write = 1 at cycle 2.
- Load to r7 with dmem_ready low for 3 cycles, rdata = 0xCAFE -> stall_out high for 3 cycles, MEM/WB bubbles meanwhile, then mem_wb_write_reg_addr = 7 and data 0xCAFE.
- Store (addr 0x40, data 0xBEEF) with dmem_ready = 1 -> dmem_we for 1 cycle, dmem_addr = 0x40, no stall, mem_wb_reg_write = 0.
- flush with a valid reg_write op in EX -> ex_mem_reg_write = 0 the next cycle; flush during stall_out -> ignored, held op preserved.
- Reset asserted during WAIT -> all outputs 0 the next cycle, FSM IDLE, no write-back.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, dmem_ready held low -> stall_out drops after 4 WAIT cycles, mem_error = 1 and stays 1, mem_wb_reg_write = 0.
